// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a single-port memory
module mem_arbiter #(
  parameter int MAX_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int STREAK_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_grant_if;
  logic                w_grant_d;
  logic                w_if_qual;
  logic                w_d_qual;
  logic                w_arb_en;
  logic [STREAK_W-1:0] r_streak;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_if_ack;
  logic        r_d_ack;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  // A request whose ack is showing has just been served and must not be re-granted.
  assign w_if_qual = if_req & ~r_if_ack;
  assign w_d_qual  = d_req & ~r_d_ack;
  // The ack cycle is a turnaround: the finished requester gets one cycle to
  // drop or re-issue, so a continuously re-requesting data port still competes
  // with a waiting fetch and the streak limit decides between them.
  assign w_arb_en  = ~r_if_ack & ~r_d_ack;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and grant decode.
  always_comb begin
    w_next_state = r_state;
    w_grant_if   = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_en) begin
          if (w_d_qual && !(w_if_qual && (r_streak == STREAK_MAX))) begin
            w_grant_d    = 1'b1;
            w_next_state = BUSY_D;
          end else if (w_if_qual) begin
            w_grant_if   = 1'b1;
            w_next_state = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Memory command capture, completion and read-data return.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
      end else if (w_grant_if) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= 32'd0;
      end else if (mem_ready && (r_state != IDLE)) begin
        r_mem_req <= 1'b0;
        if (r_state == BUSY_IF) begin
          r_if_rdata <= mem_rdata;
          r_if_ack   <= 1'b1;
        end else begin
          if (!r_mem_we) r_d_rdata <= mem_rdata;
          r_d_ack <= 1'b1;
        end
      end
    end
  end

  // Consecutive data grants while a fetch is pending, saturating at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_streak <= '0;
    end else if (w_grant_d) begin
      if (!if_req)                    r_streak <= '0;
      else if (r_streak != STREAK_MAX) r_streak <= r_streak + STREAK_W'(1);
    end else if (w_grant_if) begin
      r_streak <= '0;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign stall_if  = if_req & ~r_if_ack;
  assign stall_mem = d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;

  int n_compared;
  int n_mismatched;

  mem_arbiter #(.MAX_STREAK(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = 32'd0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = 32'd0;
    d_wdata   = 32'd0;
    mem_rdata = 32'd0;
    mem_ready = 1'b0;
    step();
    check_eq("rst_mem_req",  mem_req,  0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_if_ack",   if_ack,   0);
    check_eq("rst_d_ack",    d_ack,    0);
    check_eq("rst_d_rdata",  d_rdata,  0);
    step();
    reset = 1'b0;
    step();

    // Fetch with two wait cycles: ack four cycles after the request.
    if_req = 1'b1; if_addr = 32'h0000_0040;
    step();
    check_eq("f_mem_req",  mem_req,  1);
    check_eq("f_mem_addr", mem_addr, 32'h40);
    check_eq("f_mem_we",   mem_we,   0);
    check_eq("f_stall_if", stall_if, 1);
    step();
    check_eq("f_mem_req_hold", mem_req, 1);
    check_eq("f_no_ack_early", if_ack,  0);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h8C22_0004;
    step();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check_eq("f_if_ack",   if_ack,   1);
    check_eq("f_if_rdata", if_rdata, 32'h8C22_0004);
    check_eq("f_mem_req_clr", mem_req, 0);
    check_eq("f_stall_if_ack", stall_if, 0);
    if_req = 1'b0;
    step();
    check_eq("f_ack_pulse", if_ack,   0);
    check_eq("f_rdata_hold", if_rdata, 32'h8C22_0004);

    // Load with one wait cycle to give d_rdata a known value.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    step();
    check_eq("lw_mem_addr", mem_addr, 32'h200);
    step();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ready = 1'b0;
    check_eq("lw_d_ack",   d_ack,   1);
    check_eq("lw_d_rdata", d_rdata, 32'hCAFE_F00D);
    d_req = 1'b0;
    step();

    // Store with zero-latency memory: d_rdata untouched.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    step();
    check_eq("sw_mem_we",    mem_we,    1);
    check_eq("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check_eq("sw_mem_addr",  mem_addr,  32'h100);
    check_eq("sw_stall_mem", stall_mem, 1);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ready = 1'b0;
    check_eq("sw_d_ack",     d_ack,     1);
    check_eq("sw_d_rdata",   d_rdata,   32'hCAFE_F00D);
    check_eq("sw_stall_mem_ack", stall_mem, 0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    check_eq("sw_ack_pulse", d_ack, 0);

    // Simultaneous fetch and load with streak 0: data first, fetch next.
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_addr = 32'h300;
    step();
    check_eq("both_d_first", mem_addr, 32'h300);
    check_eq("both_stall_if1", stall_if, 1);
    mem_ready = 1'b1; mem_rdata = 32'h11;
    step();
    mem_ready = 1'b0;
    check_eq("both_d_ack", d_ack, 1);
    check_eq("both_stall_if2", stall_if, 1);
    d_req = 1'b0;
    step();
    check_eq("both_stall_if3", stall_if, 1);
    step();
    check_eq("both_if_req", mem_req, 1);
    check_eq("both_if_addr", mem_addr, 32'h80);
    mem_ready = 1'b1; mem_rdata = 32'h22;
    step();
    mem_ready = 1'b0;
    check_eq("both_if_ack", if_ack, 1);
    if_req = 1'b0;
    step();

    // Continuous data re-requests against a waiting fetch: D,D,D,D,IF.
    if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("streak_req_%0d", i), mem_req, 1);
      check_eq($sformatf("streak_addr_%0d", i), mem_addr, (i == 4) ? 32'h44 : 32'h400 + 32'(i));
      mem_ready = 1'b1; mem_rdata = 32'h1000 + 32'(i);
      step();
      mem_ready = 1'b0;
      check_eq($sformatf("streak_if_ack_%0d", i), if_ack, (i == 4) ? 1 : 0);
      check_eq($sformatf("streak_d_ack_%0d", i),  d_ack,  (i == 4) ? 0 : 1);
      if (i < 4) d_addr = 32'h400 + 32'(i + 1);
      else       if_req = 1'b0;
      step();
    end
    check_eq("streak_if_rdata", if_rdata, 32'h1004);
    step();
    check_eq("streak_d_after", mem_addr, 32'h404);
    mem_ready = 1'b1; mem_rdata = 32'h55;
    step();
    mem_ready = 1'b0;
    check_eq("streak_d_after_ack", d_ack, 1);
    d_req = 1'b0;
    step();

    // Reset while a store waits for memory.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h55AA_55AA;
    step();
    check_eq("rb_mem_req", mem_req, 1);
    step();
    reset = 1'b1;
    #1;
    check_eq("rb_mem_req_clr",   mem_req,   0);
    check_eq("rb_mem_we_clr",    mem_we,    0);
    check_eq("rb_mem_addr_clr",  mem_addr,  0);
    check_eq("rb_mem_wdata_clr", mem_wdata, 0);
    check_eq("rb_d_rdata_clr",   d_rdata,   0);
    check_eq("rb_if_rdata_clr",  if_rdata,  0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    reset = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step();
    mem_ready = 1'b0;
    check_eq("rb_no_d_ack1", d_ack, 0);
    step();
    check_eq("rb_no_d_ack2", d_ack,   0);
    check_eq("rb_idle_req",  mem_req, 0);
    check_eq("rb_d_rdata",   d_rdata, 0);

    // Stray mem_ready in IDLE, then a load held past its ack.
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ready = 1'b0;
    check_eq("stray_d_ack",  d_ack,   0);
    check_eq("stray_if_ack", if_ack,  0);
    check_eq("stray_req",    mem_req, 0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    step();
    check_eq("hold_addr1", mem_addr, 32'h600);
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    step();
    mem_ready = 1'b0;
    check_eq("hold_d_ack1", d_ack,   1);
    check_eq("hold_rdata1", d_rdata, 32'hA5A5_A5A5);
    d_addr = 32'h604;
    step();
    check_eq("hold_no_regrant", mem_req, 0);
    check_eq("hold_ack_low",    d_ack,   0);
    step();
    check_eq("hold_regrant", mem_req,  1);
    check_eq("hold_addr2",   mem_addr, 32'h604);
    mem_ready = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    step();
    mem_ready = 1'b0;
    check_eq("hold_d_ack2", d_ack,   1);
    check_eq("hold_rdata2", d_rdata, 32'h5A5A_5A5A);
    d_req = 1'b0;
    step();
    check_eq("hold_idle", mem_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
